// File: rtl/ahb_mux_slave_dp_pkg.sv
// Shared constants and helpers for the AHB slave-side multiplexer.
// Select vectors up to 64 channels are supported by is_onehot_or_zero.
package AHB_package;

    localparam int AHB_ADDR_PAYLOAD = 46;
    localparam int AHB_DATA_PAYLOAD = 32;

    function automatic logic is_onehot_or_zero(
        input logic [63:0] v,
        input int          n
    );
        logic [63:0] mask;
        logic [63:0] m;
        mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        m = v & mask;
        return (m & (m - 64'd1)) == 64'd0;
    endfunction

endpackage

// File: rtl/ahb_mux_slave_dp_onehot_mux.sv
// Combinational one-hot multiplexer; drives zero for an empty
// or multi-hot select so a bad grant never leaks a payload.
module ahb_onehot_mux
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM = 3,
    parameter int WIDTH       = 32
) (
    input  logic [CHANNEL_NUM-1:0]            sel,
    input  logic [CHANNEL_NUM-1:0][WIDTH-1:0] din,
    output logic [WIDTH-1:0]                  dout
);

    always_comb begin
        dout = '0;
        if (is_onehot_or_zero(64'(sel), CHANNEL_NUM)) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (sel[i]) dout |= din[i];
            end
        end
    end

endmodule

// File: rtl/ahb_mux_slave_dp.sv
// AHB slave-side mux with stall-held address grant and registered data owner.
// Optional sticky select checker enabled by macro AHB_MUX_SEL_CHK_EN.
module ahb_mux_slave_dp
    import AHB_package::*;
#(
    parameter int CHANNEL_NUM  = 3,
    parameter int ADDR_PAYLOAD = AHB_ADDR_PAYLOAD,
    parameter int DATA_PAYLOAD = AHB_DATA_PAYLOAD
) (
    input  logic                                   hclk,
    input  logic                                   hresetn,
    input  logic [CHANNEL_NUM-1:0][ADDR_PAYLOAD-1:0] addr_in,
    input  logic [CHANNEL_NUM-1:0][DATA_PAYLOAD-1:0] data_in,
    input  logic [CHANNEL_NUM-1:0]                 sel,
    input  logic                                   hready,
    output logic [ADDR_PAYLOAD-1:0]                addr_out,
    output logic [DATA_PAYLOAD-1:0]                data_out,
    output logic [CHANNEL_NUM-1:0]                 dp_sel,
    output logic                                   dp_valid,
    output logic                                   sel_err
);

    logic                   stalled;
    logic [CHANNEL_NUM-1:0] ap_hold;
    logic [CHANNEL_NUM-1:0] ap_eff;
    logic                   ap_onehot;

    // Freeze the grant seen when the wait state began.
    assign ap_eff    = stalled ? ap_hold : sel;
    assign ap_onehot = (|ap_eff) &&
                       is_onehot_or_zero(64'(ap_eff), CHANNEL_NUM);
    assign dp_valid  = |dp_sel;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            stalled <= 1'b0;
            ap_hold <= '0;
            dp_sel  <= '0;
        end else begin
            stalled <= ~hready;
            ap_hold <= ap_eff;
            if (hready) dp_sel <= ap_onehot ? ap_eff : '0;
        end
    end

    ahb_onehot_mux #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .WIDTH       (ADDR_PAYLOAD)
    ) u_addr_mux (
        .sel  (ap_eff),
        .din  (addr_in),
        .dout (addr_out)
    );

    ahb_onehot_mux #(
        .CHANNEL_NUM (CHANNEL_NUM),
        .WIDTH       (DATA_PAYLOAD)
    ) u_data_mux (
        .sel  (dp_sel),
        .din  (data_in),
        .dout (data_out)
    );

`ifdef AHB_MUX_SEL_CHK_EN
    logic sel_bad;

    assign sel_bad = !is_onehot_or_zero(64'(sel), CHANNEL_NUM) ||
                     (stalled && (sel != ap_hold));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) sel_err <= 1'b0;
        else if (sel_bad) sel_err <= 1'b1;
    end
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_mux_slave_dp.sv
// Scoreboard bench: stimulus pushes hand-computed expectations,
// a monitor pops and compares them at the falling clock edge.
module tb_ahb_mux_slave_dp;

    localparam int N  = 3;
    localparam int AW = 46;
    localparam int DW = 32;

`ifdef AHB_MUX_SEL_CHK_EN
    localparam logic E = 1'b1;
`else
    localparam logic E = 1'b0;
`endif

    localparam logic [AW-1:0] A0 = 46'h0123_4567_89A0;
    localparam logic [AW-1:0] A1 = 46'h1B2C_3D4E_5F61;
    localparam logic [AW-1:0] A2 = 46'h2AAA_5555_0F02;
    localparam logic [DW-1:0] D0 = 32'hDEAD_0000;
    localparam logic [DW-1:0] D1 = 32'hBEEF_1111;
    localparam logic [DW-1:0] D2 = 32'hCAFE_2222;

    logic                 hclk;
    logic                 hresetn;
    logic [N-1:0][AW-1:0] addr_in;
    logic [N-1:0][DW-1:0] data_in;
    logic [N-1:0]         sel;
    logic                 hready;
    logic [AW-1:0]        addr_out;
    logic [DW-1:0]        data_out;
    logic [N-1:0]         dp_sel;
    logic                 dp_valid;
    logic                 sel_err;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  dp;
        logic          err;
        string         nm;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 0;

    ahb_mux_slave_dp #(
        .CHANNEL_NUM  (N),
        .ADDR_PAYLOAD (AW),
        .DATA_PAYLOAD (DW)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .sel      (sel),
        .hready   (hready),
        .addr_out (addr_out),
        .data_out (data_out),
        .dp_sel   (dp_sel),
        .dp_valid (dp_valid),
        .sel_err  (sel_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic push(input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input logic [N-1:0] edp, input logic eerr,
                        input string nm);
        exp_t e;
        e.a = ea; e.d = ed; e.dp = edp; e.err = eerr; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [N-1:0] s,
                        input logic rdy, input logic [AW-1:0] ea,
                        input logic [DW-1:0] ed, input logic [N-1:0] edp,
                        input logic eerr, input string nm);
        @(posedge hclk);
        #1;
        hresetn = r;
        sel     = s;
        hready  = rdy;
        push(ea, ed, edp, eerr, nm);
    endtask

    // Monitor: pops one expectation per falling edge or explicit strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk or chk_ev);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_chk++;
                if (addr_out !== e.a) begin
                    n_fail++;
                    $display("FAIL %s addr_out got %h want %h", e.nm, addr_out, e.a);
                end
                n_chk++;
                if (data_out !== e.d) begin
                    n_fail++;
                    $display("FAIL %s data_out got %h want %h", e.nm, data_out, e.d);
                end
                n_chk++;
                if (dp_sel !== e.dp) begin
                    n_fail++;
                    $display("FAIL %s dp_sel got %b want %b", e.nm, dp_sel, e.dp);
                end
                n_chk++;
                if (dp_valid !== (|e.dp)) begin
                    n_fail++;
                    $display("FAIL %s dp_valid got %b want %b", e.nm, dp_valid, |e.dp);
                end
                n_chk++;
                if (sel_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s sel_err got %b want %b", e.nm, sel_err, e.err);
                end
            end
        end
    end

    initial begin
        addr_in[0] = A0; addr_in[1] = A1; addr_in[2] = A2;
        data_in[0] = D0; data_in[1] = D1; data_in[2] = D2;
        hresetn = 1'b0;
        sel     = 3'b010;
        hready  = 1'b1;

        step(0, 3'b010, 1, A1, '0, 3'b000, 0, "rst_hold");
        step(1, 3'b010, 1, A1, '0, 3'b000, 0, "rst_release");
        step(1, 3'b001, 1, A0, D1, 3'b010, 0, "b2b_0");
        step(1, 3'b010, 1, A1, D0, 3'b001, 0, "b2b_1");
        step(1, 3'b100, 1, A2, D1, 3'b010, 0, "b2b_2");
        step(1, 3'b100, 0, A2, D2, 3'b100, 0, "stall_start");
        step(1, 3'b001, 0, A2, D2, 3'b100, 0, "stall_switch");
        step(1, 3'b001, 0, A2, D2, 3'b100, E, "stall_hold");
        step(1, 3'b001, 1, A2, D2, 3'b100, E, "stall_last");
        step(1, 3'b001, 1, A0, D2, 3'b100, E, "post_stall");
        step(0, 3'b001, 1, A0, '0, 3'b000, 0, "rst_pulse");
        step(1, 3'b011, 1, '0, '0, 3'b000, 0, "multi_hot");
        step(1, 3'b001, 1, A0, '0, 3'b000, E, "multi_hot_next");
        step(1, 3'b010, 1, A1, D0, 3'b001, E, "recover");
        step(1, 3'b010, 0, A1, D1, 3'b010, E, "stall2_start");
        step(1, 3'b010, 0, A1, D1, 3'b010, E, "stall2_mid");

        // Asynchronous reset in the middle of a stall, away from any edge.
        @(negedge hclk);
        #1;
        sel     = 3'b100;
        hresetn = 1'b0;
        #1;
        push(A2, '0, 3'b000, 0, "async_rst");
        ->chk_ev;

        step(1, 3'b100, 1, A2, '0, 3'b000, 0, "async_release");
        step(1, 3'b001, 1, A0, D2, 3'b100, 0, "after_release");

        @(negedge hclk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue_left got %0d want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
